// File: rtl/riscv_proc_div_issue_if.sv
// Request/response bundle between the divide issue controller and the iterative divider.
// Request: a transfer happens on a cycle where div_val & div_rdy are both high; while div_val=1 and
// div_rdy=0 the payload is held stable. Response: div_result_val is a single-cycle pulse with no ready.
interface riscv_proc_div_issue_if #(
    parameter int W = 64
);
    logic         div_val;
    logic         div_rdy;
    logic [2:0]   div_fn;
    logic [4:0]   div_waddr;
    logic [W-1:0] div_rs1;
    logic [W-1:0] div_rs2;
    logic         div_result_val;
    logic [4:0]   div_result_tag;
    logic [W-1:0] div_result_bits;

    modport master (
        output div_val, div_fn, div_waddr, div_rs1, div_rs2,
        input  div_rdy, div_result_val, div_result_tag, div_result_bits
    );

    modport slave (
        input  div_val, div_fn, div_waddr, div_rs1, div_rs2,
        output div_rdy, div_result_val, div_result_tag, div_result_bits
    );
endinterface

// File: rtl/riscv_proc_div_issue.sv
// Divide issue controller: request issue, pending-register scoreboard, writeback arbitration.
// Optional macro DIV_ISSUE_BYPASS_EN writes a result back in its arrival cycle when the port is free.
module riscv_proc_div_issue #(
    parameter int W          = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dec_val,
    input  logic                          dec_div_val,
    input  logic [2:0]                    dec_div_fn,
    input  logic [4:0]                    dec_waddr,
    input  logic                          dec_wen,
    input  logic [4:0]                    dec_raddr1,
    input  logic [4:0]                    dec_raddr2,
    input  logic                          dec_ren1,
    input  logic                          dec_ren2,
    input  logic [W-1:0]                  dec_rs1_data,
    input  logic [W-1:0]                  dec_rs2_data,
    output logic                          dec_stall,
    riscv_proc_div_issue_if.master        div,
    input  logic                          wb_pipe_val,
    output logic                          lw_wb_val,
    output logic [4:0]                    lw_wb_waddr,
    output logic [W-1:0]                  lw_wb_data,
    output logic                          proto_err
);
    localparam int CW = $clog2(STARVE_MAX + 1) + 1;

    logic         req_val_q, req_val_d;
    logic         outstanding_q, outstanding_d;
    logic         hold_val_q, hold_val_d;
    logic [4:0]   hold_tag_q, hold_tag_d;
    logic [W-1:0] hold_data_q, hold_data_d;
    logic [2:0]   fn_q, fn_d;
    logic [4:0]   waddr_q, waddr_d;
    logic [W-1:0] rs1_q, rs1_d;
    logic [W-1:0] rs2_q, rs2_d;
    logic [31:0]  sb_q, sb_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic         proto_err_q, proto_err_d;

    logic         busy, starve, raw, waw, accept, fire, result_ok, bypass, hold_drain;
    logic [31:0]  sb_eff;

    assign busy      = req_val_q | outstanding_q | hold_val_q;
    assign starve    = (starve_cnt_q >= CW'(STARVE_MAX));
    assign fire      = req_val_q & div.div_rdy;
    // A result is only legal when exactly one is expected and the hold slot is free.
    assign result_ok = div.div_result_val & outstanding_q & ~hold_val_q;

`ifdef DIV_ISSUE_BYPASS_EN
    assign bypass = result_ok & ~wb_pipe_val;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        lw_wb_val   = 1'b0;
        lw_wb_waddr = hold_tag_q;
        lw_wb_data  = hold_data_q;
        if (bypass) begin
            lw_wb_val   = (div.div_result_tag != 5'd0);
            lw_wb_waddr = div.div_result_tag;
            lw_wb_data  = div.div_result_bits;
        end else begin
            lw_wb_val   = hold_val_q & ~wb_pipe_val & (hold_tag_q != 5'd0);
        end
    end

    // A zero-tag result is discarded, so it leaves the hold slot regardless of the pipeline.
    assign hold_drain = hold_val_q & ((hold_tag_q == 5'd0) | ~wb_pipe_val);

    always_comb begin
        sb_eff = sb_q;
`ifdef DIV_ISSUE_BYPASS_EN
        if (lw_wb_val) sb_eff[lw_wb_waddr] = 1'b0;
`endif
    end

    assign raw       = (dec_ren1 & (dec_raddr1 != 5'd0) & sb_eff[dec_raddr1])
                     | (dec_ren2 & (dec_raddr2 != 5'd0) & sb_eff[dec_raddr2]);
    assign waw       = dec_wen & (dec_waddr != 5'd0) & sb_eff[dec_waddr];
    assign dec_stall = (dec_val & (raw | waw | (dec_div_val & busy))) | starve;
    assign accept    = dec_val & dec_div_val & ~dec_stall;

    always_comb begin
        req_val_d     = req_val_q;
        outstanding_d = outstanding_q;
        hold_val_d    = hold_val_q;
        hold_tag_d    = hold_tag_q;
        hold_data_d   = hold_data_q;
        fn_d          = fn_q;
        waddr_d       = waddr_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        sb_d          = sb_q;
        starve_cnt_d  = '0;
        proto_err_d   = proto_err_q | (div.div_result_val & (~outstanding_q | hold_val_q));

        if (accept) begin
            req_val_d = 1'b1;
            fn_d      = dec_div_fn;
            waddr_d   = dec_waddr;
            rs1_d     = dec_rs1_data;
            rs2_d     = dec_rs2_data;
        end else if (fire) begin
            req_val_d = 1'b0;
        end

        if (fire)      outstanding_d = 1'b1;
        if (result_ok) outstanding_d = 1'b0;

        if (hold_drain) hold_val_d = 1'b0;
        if (result_ok && !bypass) begin
            hold_val_d  = 1'b1;
            hold_tag_d  = div.div_result_tag;
            hold_data_d = div.div_result_bits;
        end

        // Clear before set so a same-cycle collision leaves the bit pending.
        if (lw_wb_val) sb_d[lw_wb_waddr] = 1'b0;
        if (accept && dec_waddr != 5'd0) sb_d[dec_waddr] = 1'b1;

        if (hold_val_q && wb_pipe_val) begin
            starve_cnt_d = starve ? starve_cnt_q : starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_val_q     <= 1'b0;
            outstanding_q <= 1'b0;
            hold_val_q    <= 1'b0;
            hold_tag_q    <= '0;
            hold_data_q   <= '0;
            fn_q          <= '0;
            waddr_q       <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            sb_q          <= '0;
            starve_cnt_q  <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            req_val_q     <= req_val_d;
            outstanding_q <= outstanding_d;
            hold_val_q    <= hold_val_d;
            hold_tag_q    <= hold_tag_d;
            hold_data_q   <= hold_data_d;
            fn_q          <= fn_d;
            waddr_q       <= waddr_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            sb_q          <= sb_d;
            starve_cnt_q  <= starve_cnt_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign div.div_val   = req_val_q;
    assign div.div_fn    = fn_q;
    assign div.div_waddr = waddr_q;
    assign div.div_rs1   = rs1_q;
    assign div.div_rs2   = rs2_q;
    assign proto_err     = proto_err_q;
endmodule

// File: tb/tb_riscv_proc_div_issue.sv
// Bench for riscv_proc_div_issue: directed scenarios plus randomized divides, with
// request and writeback scoreboards fed at stimulus time and drained by negedge monitors.
module tb_riscv_proc_div_issue;
  localparam int W = 64;
`ifdef DIV_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]   fn;
    logic [4:0]   waddr;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
  } req_t;

  typedef struct packed {
    logic [4:0]   waddr;
    logic [W-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dec_val = 0, dec_div_val = 0, dec_wen = 0, dec_ren1 = 0, dec_ren2 = 0;
  logic [2:0] dec_div_fn = 0;
  logic [4:0] dec_waddr = 0, dec_raddr1 = 0, dec_raddr2 = 0;
  logic [W-1:0] dec_rs1_data = 0, dec_rs2_data = 0;
  logic dec_stall, wb_pipe_val = 0, lw_wb_val, proto_err;
  logic [4:0] lw_wb_waddr;
  logic [W-1:0] lw_wb_data;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  riscv_proc_div_issue_if #(.W(W)) dif ();

  riscv_proc_div_issue #(.W(W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .dec_val(dec_val), .dec_div_val(dec_div_val), .dec_div_fn(dec_div_fn),
    .dec_waddr(dec_waddr), .dec_wen(dec_wen),
    .dec_raddr1(dec_raddr1), .dec_raddr2(dec_raddr2),
    .dec_ren1(dec_ren1), .dec_ren2(dec_ren2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_stall(dec_stall), .div(dif.master),
    .wb_pipe_val(wb_pipe_val), .lw_wb_val(lw_wb_val),
    .lw_wb_waddr(lw_wb_waddr), .lw_wb_data(lw_wb_data), .proto_err(proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitors: request handshakes and writebacks pop the scoreboards
  always @(negedge clk) begin
    if (!reset && dif.div_val && dif.div_rdy) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 1, 0);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("req_fn", W'(dif.div_fn), W'(e.fn));
        check("req_waddr", W'(dif.div_waddr), W'(e.waddr));
        check("req_rs1", dif.div_rs1, e.rs1);
        check("req_rs2", dif.div_rs2, e.rs2);
      end
    end
    if (!reset && lw_wb_val) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_waddr", W'(lw_wb_waddr), W'(e.waddr));
        check("wb_data", lw_wb_data, e.data);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_val = 0; dec_div_val = 0; dec_wen = 0; dec_ren1 = 0; dec_ren2 = 0;
    dec_div_fn = 0; dec_waddr = 0; dec_raddr1 = 0; dec_raddr2 = 0;
    dec_rs1_data = 0; dec_rs2_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_dec();
    wb_pipe_val = 0;
    dif.div_rdy = 0;
    dif.div_result_val = 0;
    dif.div_result_tag = 0;
    dif.div_result_bits = 0;
    repeat (2) step();
    reset = 0;
    req_q.delete();
    wb_q.delete();
  endtask

  task automatic issue_div(input logic [2:0] fn, input logic [4:0] wa,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    req_t r;
    dec_val = 1; dec_div_val = 1; dec_div_fn = fn; dec_waddr = wa; dec_wen = 1;
    dec_rs1_data = a; dec_rs2_data = b;
    @(negedge clk);
    check("accept_stall", W'(dec_stall), 0);
    r.fn = fn; r.waddr = wa; r.rs1 = a; r.rs2 = b;
    req_q.push_back(r);
    step();
    clear_dec();
  endtask

  task automatic wait_fire(input int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (dif.div_val && dif.div_rdy) seen = 1;
      step();
    end
    check("fire_seen", W'(seen), 1);
  endtask

  task automatic send_result(input logic [4:0] tag, input logic [W-1:0] data, input bit exp_wb);
    wb_t e;
    if (exp_wb) begin
      e.waddr = tag; e.data = data;
      wb_q.push_back(e);
    end
    dif.div_result_val = 1; dif.div_result_tag = tag; dif.div_result_bits = data;
    step();
    dif.div_result_val = 0;
  endtask

  task automatic wait_wb_drain(input int max);
    for (int i = 0; i < max && wb_q.size() != 0; i++) step();
    check("wb_drain", W'(wb_q.size()), 0);
  endtask

  task automatic hz(input string tag, input logic [4:0] r1, input logic ren,
                    input logic [4:0] wa, input logic wen, input logic exp);
    dec_val = 1; dec_raddr1 = r1; dec_ren1 = ren; dec_waddr = wa; dec_wen = wen;
    @(negedge clk);
    check(tag, W'(dec_stall), W'(exp));
    step();
    clear_dec();
  endtask

  // main sequence
  initial begin
    dif.div_rdy = 0;
    dif.div_result_val = 0;
    dif.div_result_tag = 0;
    dif.div_result_bits = 0;
    do_reset();

    @(negedge clk);
    check("rst_stall", W'(dec_stall), 0);
    check("rst_div_val", W'(dif.div_val), 0);
    check("rst_wb_val", W'(lw_wb_val), 0);
    check("rst_proto", W'(proto_err), 0);
    check("rst_wb_addr", W'(lw_wb_waddr), 0);
    check("rst_wb_data", lw_wb_data, 0);
    check("rst_div_rs1", dif.div_rs1, 0);
    check("rst_div_waddr", W'(dif.div_waddr), 0);
    step();

    // basic divide, divider ready immediately
    dif.div_rdy = 1;
    issue_div(3'd0, 5'd5, 100, 7);
    @(negedge clk);
    check("t1_div_val", W'(dif.div_val), 1);
    step();
    @(negedge clk);
    check("t1_div_val_drop", W'(dif.div_val), 0);
    step();
    hz("t1_raw_r5", 5'd5, 1, 5'd0, 0, 1);
    hz("t1_raw_r6", 5'd6, 1, 5'd0, 0, 0);
    hz("t1_raw_r0", 5'd0, 1, 5'd0, 0, 0);
    hz("t1_waw_r5", 5'd0, 0, 5'd5, 1, 1);
    wb_q.push_back('{waddr: 5'd5, data: 64'd14});
    dif.div_result_val = 1; dif.div_result_tag = 5; dif.div_result_bits = 14;
    @(negedge clk);
    check("t1_wb_same_cycle", W'(lw_wb_val), W'(BYP));
    step();
    dif.div_result_val = 0;
    if (!BYP) begin
      @(negedge clk);
      check("t1_wb_next_cycle", W'(lw_wb_val), 1);
      step();
    end
    hz("t1_raw_r5_after", 5'd5, 1, 5'd0, 0, 0);

    // divider backpressure for 10 cycles
    dif.div_rdy = 0;
    issue_div(3'd1, 5'd7, 1000, 33);
    for (int i = 0; i < 10; i++) begin
      dec_val = 1; dec_div_val = 1; dec_waddr = 8; dec_wen = 1;
      @(negedge clk);
      check("t2_div_val", W'(dif.div_val), 1);
      check("t2_rs1", dif.div_rs1, 1000);
      check("t2_rs2", dif.div_rs2, 33);
      check("t2_waddr", W'(dif.div_waddr), 7);
      check("t2_second_stall", W'(dec_stall), 1);
      step();
    end
    clear_dec();
    dif.div_rdy = 1;
    wait_fire(1);
    send_result(5'd7, 64'd30, 1);
    wait_wb_drain(4);

    // writeback starvation
    issue_div(3'd2, 5'd9, 50, 5);
    wait_fire(3);
    wb_pipe_val = 1;
    wb_q.push_back('{waddr: 5'd9, data: 64'd10});
    dif.div_result_val = 1; dif.div_result_tag = 9; dif.div_result_bits = 10;
    @(negedge clk);
    check("t3_wb_blocked0", W'(lw_wb_val), 0);
    step();
    dif.div_result_val = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t3_wb_blocked", W'(lw_wb_val), 0);
      check("t3_starve_stall", W'(dec_stall), W'(k >= 5));
      step();
    end
    wb_pipe_val = 0;
    @(negedge clk);
    check("t3_wb_release", W'(lw_wb_val), 1);
    step();
    @(negedge clk);
    check("t3_stall_clear", W'(dec_stall), 0);
    step();

    // divide to x0
    issue_div(3'd3, 5'd0, 77, 7);
    hz("t4_raw_r0", 5'd0, 1, 5'd0, 1, 0);
    send_result(5'd0, 64'd11, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_no_wb", W'(lw_wb_val), 0);
      step();
    end
    dec_val = 1; dec_div_val = 1;
    @(negedge clk);
    check("t4_idle_again", W'(dec_stall), 0);
    clear_dec();
    step();
    check("t4_proto_clean", W'(proto_err), 0);

    // spurious result, reset mid-divide, result after reset
    send_result(5'd4, 64'd1, 0);
    @(negedge clk);
    check("t5_proto_set", W'(proto_err), 1);
    repeat (3) step();
    check("t5_proto_sticky", W'(proto_err), 1);
    dif.div_rdy = 0;
    issue_div(3'd0, 5'd3, 9, 3);
    step();
    do_reset();
    @(negedge clk);
    check("t5_rst_proto", W'(proto_err), 0);
    check("t5_rst_div_val", W'(dif.div_val), 0);
    step();
    dec_val = 1; dec_div_val = 1; dec_ren1 = 1; dec_raddr1 = 3;
    @(negedge clk);
    check("t5_rst_stall", W'(dec_stall), 0);
    clear_dec();
    step();
    send_result(5'd3, 64'd3, 0);
    @(negedge clk);
    check("t5_late_result", W'(proto_err), 1);
    step();
    do_reset();

    // randomized divides with random ready delay and writeback contention
    for (int n = 0; n < 8; n++) begin
      logic [4:0]   wa;
      logic [W-1:0] a, b;
      int           d;
      wa = 5'($urandom_range(1, 31));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      d  = $urandom_range(0, 4);
      dif.div_rdy = 0;
      issue_div(3'($urandom_range(0, 7)), wa, a, b);
      repeat (d) step();
      dif.div_rdy = 1;
      wait_fire(2);
      repeat ($urandom_range(0, 3)) step();
      wb_pipe_val = 1'($urandom_range(0, 1));
      send_result(wa, a ^ b, 1);
      repeat ($urandom_range(0, 2)) step();
      wb_pipe_val = 0;
      wait_wb_drain(10);
      check("rand_proto", W'(proto_err), 0);
    end

    repeat (2) step();
    check("req_q_empty", W'(req_q.size()), 0);
    check("wb_q_empty", W'(wb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_proc_div_issue.md
Name: riscv_proc_div_issue

Overview:
Issue-side controller for the iterative divider: the initiator and consumer of the divider's request/response interface.
- Accepts divide instructions from decode, drives the divider's valid/ready request port with held operands, and captures the divider's single-cycle result pulse.
- Tracks pending destination registers in a scoreboard so dependent instructions stall.
- Arbitrates the divide result onto a shared writeback port, giving the main pipeline priority.

Parameters:
W, 64, datapath width (even, >= 8)
STARVE_MAX, 4, consecutive cycles a held result may lose writeback arbitration before decode is stalled to drain it

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dec_val  in  1  valid instruction in decode
dec_div_val  in  1  decode instruction is a divide (qualified by dec_val)
dec_div_fn  in  3  divide function code (DIV_64D..DIV_32RU encoding)
dec_waddr  in  5  decode destination register
dec_wen  in  1  decode instruction writes dec_waddr
dec_raddr1  in  5  source 1 address
dec_raddr2  in  5  source 2 address
dec_ren1  in  1  source 1 read
dec_ren2  in  1  source 2 read
dec_rs1_data  in  W  source 1 operand
dec_rs2_data  in  W  source 2 operand
dec_stall  out  1  decode must hold its instruction
div_val  out  1  request valid to divider
div_rdy  in  1  divider ready
div_fn  out  3  held function code
div_waddr  out  5  held tag
div_rs1  out  W  held dividend
div_rs2  out  W  held divisor
div_result_val  in  1  one-cycle result pulse, no backpressure
div_result_tag  in  5  result tag
div_result_bits  in  W  result data
wb_pipe_val  in  1  main pipeline writes back this cycle (has priority)
lw_wb_val  out  1  divide result writeback strobe
lw_wb_waddr  out  5  writeback address
lw_wb_data  out  W  writeback data
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset clears req_val, outstanding, hold_val, scoreboard (32 bits), starve counter and proto_err.
  - All outputs at reset: dec_stall=0, div_val=0, lw_wb_val=0, proto_err=0; address/data outputs=0.
- Single divide in flight. Define busy = req_val | outstanding | hold_val.
- Stall: dec_stall = dec_val & (raw | waw | (dec_div_val & busy)) | starve.
  - raw: (dec_ren1 & sb[dec_raddr1]) | (dec_ren2 & sb[dec_raddr2]).
  - waw: dec_wen & sb[dec_waddr].
  - x0 reads and writes are never hazards.
- Accept: dec_val & dec_div_val & !dec_stall.
  - Next edge: req_val=1 and the fn/waddr/operands register loads.
  - sb[dec_waddr] is set if dec_waddr != 0.
  - Acceptance with dec_waddr=0 still issues the divide; its result is discarded and not written back.
- Request: div_val = req_val. Payload is stable while div_val=1 and div_rdy=0.
  - On div_val & div_rdy: req_val=0 and outstanding=1 the next edge.
  - div_val does not depend combinationally on div_rdy.
- Result: on div_result_val, hold_val=1, hold_tag/hold_data load, outstanding=0.
  - Result while outstanding=0, or while hold_val=1: proto_err=1 (sticky until reset) and the pulse is dropped.
- Writeback: lw_wb_val = hold_val & !wb_pipe_val & (hold_tag != 0).
  - lw_wb_waddr = hold_tag; lw_wb_data = hold_data.
  - The edge after lw_wb_val: hold_val=0 and sb[hold_tag]=0.
  - hold_tag=0: hold_val clears next cycle with no writeback.
- Starvation: the counter increments each cycle hold_val & wb_pipe_val, and clears otherwise.
  - starve = (count >= STARVE_MAX), asserted until hold drains.
- Scoreboard set and clear of the same bit in one cycle cannot occur with one divide in flight; if it does, set wins.
- Reset mid-operation discards all state. A divider result arriving after reset raises proto_err.

Optional Feature:
DIV_ISSUE_BYPASS_EN
- Defined: if div_result_val & !hold_val & !wb_pipe_val, the result writes back combinationally the same cycle.
  - lw_wb_* are driven from div_result_*, hold is not loaded, and the scoreboard bit clears at that edge.
  - raw/waw checks mask a register whose result is being written back that cycle.
- Undefined: every result passes through the hold register, adding 1 cycle of writeback latency.

Test Plan:
- Divide fn=DIV_64D, rs1=100, rs2=7, waddr=5; divider ready immediately -> div_val for 1 cycle with rs1=100, rs2=7, div_waddr=5. sb[5]=1 until result 14 tag 5 arrives, then lw_wb_val with addr 5, data 14 one cycle later (same cycle with DIV_ISSUE_BYPASS_EN).
- Divider holds div_rdy=0 for 10 cycles -> div_val and payload are stable all 10 cycles, handshake occurs on cycle 11, and a second dec_div_val is stalled throughout.
- After a divide to r5, decode reads r5 -> dec_stall until writeback. Reads of r6 or r0 -> no stall. A write to r5 (waw) -> stall.
- Result arrives while wb_pipe_val=1 for 6 cycles -> lw_wb_val=0 during those cycles, dec_stall asserts after 4 cycles, lw_wb_val fires the first cycle wb_pipe_val=0.
- Divide with waddr=0 -> issued and completed, no lw_wb_val, no stall on r0.
- Spurious div_result_val with nothing outstanding -> proto_err=1 and stays 1 until reset; reset mid-divide -> all flags clear, dec_stall=0.
